pipeline_stall_controller: RTL and testbench
============================================

// Module: pipeline_stall_controller
// PURPOSE
//  Central sequencer for stall, bubble and flush in the 5-stage ARM pipeline.
//  Merges three stall sources into per-stage control: the hazard detector's stall request,
//  the EXE-stage branch-taken flag and the MEM-stage SRAM ready/wait handshake.
//  Drives PC/IF-ID/ID-EXE/EXE-MEM/MEM-WB freeze, IF-ID/ID-EXE flush and the ID-EXE bubble.
//  Also keeps saturating stall statistics and a memory-wait watchdog.
// PARAMETERS
//  COUNT_WIDTH    16   width of each statistics counter (saturating)
//  TIMEOUT_WIDTH  8    width of memory-wait watchdog counter
//  MEM_TIMEOUT    200  max consecutive MEM_WAIT cycles before ERROR (1..2^TIMEOUT_WIDTH-1)
// PORTS
//  clk                        in   1   system clock, rising edge
//  reset                      in   1   asynchronous reset, active-low
//  i_Sig_Hazard_Detected      in   1   RAW hazard stall request from hazard detection unit
//  i_Sig_Branch_Taken         in   1   branch resolved taken in EXE this cycle
//  i_Sig_Memory_Request       in   1   MEM stage holds a load/store this cycle
//  i_Sig_Memory_Ready         in   1   SRAM controller completes the access this cycle
//  i_Sig_Clear_Counters       in   1   synchronous clear of statistics counters
//  o_Sig_Freeze_PC            out  1   hold PC
//  o_Sig_Freeze_IF_ID         out  1   hold IF/ID register
//  o_Sig_Freeze_ID_EXE        out  1   hold ID/EXE register
//  o_Sig_Freeze_EXE_MEM       out  1   hold EXE/MEM register
//  o_Sig_Freeze_MEM_WB        out  1   hold MEM/WB register
//  o_Sig_Flush_IF_ID          out  1   load NOP into IF/ID
//  o_Sig_Bubble_ID_EXE        out  1   load NOP into ID/EXE (flush or hazard bubble)
//  o_Sig_Timeout              out  1   sticky: watchdog expired, pipeline halted
//  o_Hazard_Stall_Count       out  COUNT_WIDTH  cycles stalled by hazard
//  o_Flush_Count              out  COUNT_WIDTH  branch flush events
//  o_Mem_Wait_Count           out  COUNT_WIDTH  cycles frozen waiting on memory
// BEHAVIOUR
//  States: S_RUN, S_MEM_WAIT, S_ERROR. Reset (reset=0, async) -> S_RUN, all counters 0,
//   o_Sig_Timeout=0, watchdog=0; while reset=0 all freeze/flush/bubble outputs forced 0.
//  Control outputs are combinational from state + current inputs (zero latency);
//   state, watchdog, counters, o_Sig_Timeout are registered.
//  Decision rule (S_RUN, and S_MEM_WAIT when i_Sig_Memory_Ready=1), priority high->low:
//   1 MEMSTALL: Memory_Request=1 & Memory_Ready=0 -> all five freezes=1, flush/bubble=0;
//     next S_MEM_WAIT, watchdog loaded with MEM_TIMEOUT-1.
//   2 FLUSH: Branch_Taken=1 -> Flush_IF_ID=1, Bubble_ID_EXE=1, no freezes; hazard ignored;
//     Flush_Count+1.
//   3 HAZARD: Hazard_Detected=1 -> Freeze_PC=1, Freeze_IF_ID=1, Bubble_ID_EXE=1;
//     Hazard_Stall_Count+1.
//   4 otherwise all control outputs 0.
//  S_MEM_WAIT: Memory_Ready=0 -> all five freezes=1, Mem_Wait_Count+1, watchdog-1;
//   watchdog==0 with Ready=0 -> next S_ERROR. Ready=1 -> apply decision rule same cycle
//   (freeze releases in that cycle), next S_RUN unless rule 1 fires again.
//   Branch/hazard inputs during wait are ignored (their stages are frozen; re-seen on release).
//  First MEMSTALL cycle (entry from S_RUN) also counts in Mem_Wait_Count.
//  S_ERROR: all five freezes=1, flush/bubble=0, o_Sig_Timeout=1; exit only via reset.
//  Counters saturate at 2^COUNT_WIDTH-1. Clear_Counters=1: all counters 0 next edge,
//   overriding same-cycle increments; state/watchdog unaffected.
//  Reset asserted mid-MEM_WAIT: immediate return to S_RUN, outputs 0, no residual stall.
//  Invariant: Flush_IF_ID and any freeze never both 1 in one cycle.
// TESTING
//  1 Hazard=1 for 2 cycles, others 0 -> Freeze_PC/IF_ID=1, Bubble=1 both cycles; Hazard_Stall_Count=2.
//  2 Branch=1 & Hazard=1 same cycle -> Flush_IF_ID=1, Bubble=1, no freeze; Flush_Count=1, Stall=0.
//  3 Mem_Request=1, Ready=0 for 3 cycles then Ready=1 -> freezes=1 for 3 cycles, 0 on 4th;
//    Mem_Wait_Count=3; state back to S_RUN.
//  4 MEM_TIMEOUT=4, Request=1, Ready held 0 -> S_ERROR after 4 wait cycles, Timeout=1,
//    stays halted until reset=0.
//  5 Branch=1 during MEM_WAIT (Ready=0) -> no flush, Flush_Count unchanged; branch
//    still high on Ready=1 cycle -> flush that cycle.
//  6 COUNT_WIDTH=4, 20 hazard cycles -> count saturates at 15; Clear_Counters=1 -> 0;
//    reset=0 mid-MEM_WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Stall/bubble/flush sequencer for the 5-stage pipeline: merges hazard, branch and memory-wait
// requests into per-stage freeze/flush controls, with saturating statistics and a memory watchdog.
module pipeline_stall_controller #(
  parameter int unsigned COUNT_WIDTH   = 16,
  parameter int unsigned TIMEOUT_WIDTH = 8,
  parameter int unsigned MEM_TIMEOUT   = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_Sig_Hazard_Detected,
  input  logic                   i_Sig_Branch_Taken,
  input  logic                   i_Sig_Memory_Request,
  input  logic                   i_Sig_Memory_Ready,
  input  logic                   i_Sig_Clear_Counters,
  output logic                   o_Sig_Freeze_PC,
  output logic                   o_Sig_Freeze_IF_ID,
  output logic                   o_Sig_Freeze_ID_EXE,
  output logic                   o_Sig_Freeze_EXE_MEM,
  output logic                   o_Sig_Freeze_MEM_WB,
  output logic                   o_Sig_Flush_IF_ID,
  output logic                   o_Sig_Bubble_ID_EXE,
  output logic                   o_Sig_Timeout,
  output logic [COUNT_WIDTH-1:0] o_Hazard_Stall_Count,
  output logic [COUNT_WIDTH-1:0] o_Flush_Count,
  output logic [COUNT_WIDTH-1:0] o_Mem_Wait_Count
);

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StError
  } state_e;

  localparam logic [TIMEOUT_WIDTH-1:0] WdLoad = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
  logic                     timeout_q;
  logic [COUNT_WIDTH-1:0]   hz_cnt_q, fl_cnt_q, mw_cnt_q;

  logic decide;
  logic freeze_all;
  logic freeze_front;
  logic flush;
  logic bubble;
  logic hz_inc, fl_inc, mw_inc;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] cnt,
                                                     input logic                   inc);
    return (inc && (cnt != '1)) ? cnt + 1'b1 : cnt;
  endfunction

  // Next state, watchdog and raw control decisions.
  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    decide       = 1'b0;
    freeze_all   = 1'b0;
    freeze_front = 1'b0;
    flush        = 1'b0;
    bubble       = 1'b0;
    hz_inc       = 1'b0;
    fl_inc       = 1'b0;
    mw_inc       = 1'b0;

    unique case (state_q)
      StRun: begin
        decide = 1'b1;
      end
      StMemWait: begin
        if (i_Sig_Memory_Ready) begin
          decide = 1'b1;
        end else begin
          // Branch/hazard are ignored here; their stages are frozen and re-present on release.
          freeze_all = 1'b1;
          mw_inc     = 1'b1;
          if (wd_q == '0) begin
            state_d = StError;
          end else begin
            wd_d = wd_q - 1'b1;
          end
        end
      end
      StError: begin
        freeze_all = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (decide) begin
      state_d = StRun;
      if (i_Sig_Memory_Request && !i_Sig_Memory_Ready) begin
        freeze_all = 1'b1;
        mw_inc     = 1'b1;
        state_d    = StMemWait;
        wd_d       = WdLoad;
      end else if (i_Sig_Branch_Taken) begin
        flush  = 1'b1;
        bubble = 1'b1;
        fl_inc = 1'b1;
      end else if (i_Sig_Hazard_Detected) begin
        freeze_front = 1'b1;
        bubble       = 1'b1;
        hz_inc       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_q | (state_d == StError);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hz_cnt_q <= '0;
      fl_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else if (i_Sig_Clear_Counters) begin
      hz_cnt_q <= '0;
      fl_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      hz_cnt_q <= sat_inc(hz_cnt_q, hz_inc);
      fl_cnt_q <= sat_inc(fl_cnt_q, fl_inc);
      mw_cnt_q <= sat_inc(mw_cnt_q, mw_inc);
    end
  end

  // Controls are combinational, so gate them with reset to guarantee no residual stall.
  always_comb begin
    o_Sig_Freeze_PC      = reset & (freeze_all | freeze_front);
    o_Sig_Freeze_IF_ID   = reset & (freeze_all | freeze_front);
    o_Sig_Freeze_ID_EXE  = reset & freeze_all;
    o_Sig_Freeze_EXE_MEM = reset & freeze_all;
    o_Sig_Freeze_MEM_WB  = reset & freeze_all;
    o_Sig_Flush_IF_ID    = reset & flush;
    o_Sig_Bubble_ID_EXE  = reset & bubble;
  end

  assign o_Sig_Timeout        = timeout_q;
  assign o_Hazard_Stall_Count = hz_cnt_q;
  assign o_Flush_Count        = fl_cnt_q;
  assign o_Mem_Wait_Count     = mw_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a cycle model pushes expected controls and
// counters per driven cycle; they are popped and compared against the DUT mid-cycle.
module tb_pipeline_stall_controller;

  localparam int unsigned CW = 4;
  localparam int unsigned TW = 8;
  localparam int unsigned MT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          hz, br, req, rdy, clr;
  logic          f_pc, f_ifid, f_idexe, f_exemem, f_memwb, fl_ifid, bub, tmo;
  logic [CW-1:0] hz_cnt, fl_cnt, mw_cnt;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .COUNT_WIDTH  (CW),
    .TIMEOUT_WIDTH(TW),
    .MEM_TIMEOUT  (MT)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_Sig_Hazard_Detected(hz),
    .i_Sig_Branch_Taken   (br),
    .i_Sig_Memory_Request (req),
    .i_Sig_Memory_Ready   (rdy),
    .i_Sig_Clear_Counters (clr),
    .o_Sig_Freeze_PC      (f_pc),
    .o_Sig_Freeze_IF_ID   (f_ifid),
    .o_Sig_Freeze_ID_EXE  (f_idexe),
    .o_Sig_Freeze_EXE_MEM (f_exemem),
    .o_Sig_Freeze_MEM_WB  (f_memwb),
    .o_Sig_Flush_IF_ID    (fl_ifid),
    .o_Sig_Bubble_ID_EXE  (bub),
    .o_Sig_Timeout        (tmo),
    .o_Hazard_Stall_Count (hz_cnt),
    .o_Flush_Count        (fl_cnt),
    .o_Mem_Wait_Count     (mw_cnt)
  );

  typedef struct packed {
    logic [6:0]    ctl;  // {pc, if_id, id_exe, exe_mem, mem_wb, flush, bubble}
    logic          to;
    logic [CW-1:0] hz;
    logic [CW-1:0] fl;
    logic [CW-1:0] mw;
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef enum int {MRun, MWait, MErr} mstate_e;
  mstate_e       m_st;
  logic [TW-1:0] m_wd;
  logic [CW-1:0] m_hz, m_fl, m_mw;
  logic          m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v, input logic inc);
    if (inc && v != {CW{1'b1}}) return v + 1'b1;
    return v;
  endfunction

  function automatic logic [6:0] model_ctl(input logic r, input logic h, input logic b,
                                           input logic q, input logic y);
    if (!r) return 7'b0000000;
    if (m_st == MErr) return 7'b1111100;
    if (m_st == MWait && !y) return 7'b1111100;
    if (q && !y) return 7'b1111100;
    if (b) return 7'b0000011;
    if (h) return 7'b1100001;
    return 7'b0000000;
  endfunction

  task automatic model_reset();
    m_st = MRun; m_wd = '0; m_hz = '0; m_fl = '0; m_mw = '0; m_to = 1'b0;
  endtask

  task automatic model_clock(input logic h, input logic b, input logic q, input logic y,
                             input logic c);
    logic    hi = 1'b0, fi = 1'b0, wi = 1'b0;
    mstate_e nst = m_st;
    if (m_st == MWait && !y) begin
      wi = 1'b1;
      if (m_wd == 0) nst = MErr;
      else m_wd = m_wd - 1'b1;
    end else if (m_st != MErr) begin
      nst = MRun;
      if (q && !y) begin
        nst = MWait; m_wd = TW'(MT - 1); wi = 1'b1;
      end else if (b) fi = 1'b1;
      else if (h) hi = 1'b1;
    end
    m_st = nst;
    if (nst == MErr) m_to = 1'b1;
    if (c) begin
      m_hz = '0; m_fl = '0; m_mw = '0;
    end else begin
      m_hz = sat(m_hz, hi); m_fl = sat(m_fl, fi); m_mw = sat(m_mw, wi);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_eq("ctl", {25'd0, f_pc, f_ifid, f_idexe, f_exemem, f_memwb, fl_ifid, bub}, 32'(e.ctl));
    check_eq("timeout", 32'(tmo), 32'(e.to));
    check_eq("hz_cnt", 32'(hz_cnt), 32'(e.hz));
    check_eq("fl_cnt", 32'(fl_cnt), 32'(e.fl));
    check_eq("mw_cnt", 32'(mw_cnt), 32'(e.mw));
    check_eq("flush_vs_freeze",
             32'(fl_ifid & (f_pc | f_ifid | f_idexe | f_exemem | f_memwb)), 32'd0);
  endtask

  // One cycle: drive on negedge, compare 1ns later, advance the model on posedge.
  task automatic step(input logic r, input logic h, input logic b, input logic q,
                      input logic y, input logic c);
    exp_t e;
    @(negedge clk);
    reset = r; hz = h; br = b; req = q; rdy = y; clr = c;
    if (!r) model_reset();
    e.ctl = model_ctl(r, h, b, q, y);
    e.to  = m_to;
    e.hz  = m_hz;
    e.fl  = m_fl;
    e.mw  = m_mw;
    sb_q.push_back(e);
    #1;
    compare();
    @(posedge clk);
    if (r) model_clock(h, b, q, y, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; hz = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0; clr = 1'b0;
    model_reset();
    do_reset();
    idle(1);

    // Hazard for two cycles
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Branch beats hazard
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Three memory-wait cycles then ready
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Branch during wait is ignored, then taken on the release cycle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);

    // Watchdog expiry: request held without ready, then halt until reset
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    do_reset();
    idle(1);

    // Hazard-count saturation, then clear overriding a same-cycle increment
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Reset asserted mid-wait with request still pending
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
